// File: rtl/mux_pkg.sv
// Shared constants for pipelined_nbyone_mux: select-mode encodings and default geometry.
package mux_pkg;

  localparam logic MODE_DIRECT   = 1'b0;
  localparam logic MODE_SCAN     = 1'b1;

  localparam int   MUX_N_DEFAULT = 4;
  localparam int   MUX_W_DEFAULT = 1;

endpackage

// File: rtl/mux2_stage.sv
// W-bit 2:1 mux node; REG=1 registers data and valid under a shared enable, REG=0 is pure logic.
module mux2_stage #(
  parameter int W   = 1,
  parameter bit REG = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         sel,
  input  logic         valid_in,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  output logic [W-1:0] q,
  output logic         valid_out
);

  logic [W-1:0] mux;

  assign mux = sel ? d1 : d0;

  generate
    if (REG) begin : g_reg
      always_ff @(posedge clk) begin
        // NOTE: data is reset along with valid so a flushed pipe presents zero, not stale bits.
        if (rst) begin
          q         <= '0;
          valid_out <= 1'b0;
        end else if (en) begin
          q         <= mux;
          valid_out <= valid_in;
        end
      end
    end else begin : g_comb
      logic unused_ctrl;
      assign unused_ctrl = ^{clk, rst, en};
      assign q           = mux;
      assign valid_out   = valid_in;
    end
  endgenerate

endmodule

// File: rtl/pipelined_nbyone_mux.sv
// N:1 W-bit mux tree with valid/ready handshake, direct/scan select and a global stall enable.
// Build option MUX_PIPE_EN: register every tree level (latency SELW) instead of one output register.
module pipelined_nbyone_mux
  import mux_pkg::*;
#(
  parameter int N    = MUX_N_DEFAULT,
  parameter int W    = MUX_W_DEFAULT,
  parameter int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*W-1:0]  data_in,
  input  logic [SELW-1:0] sel,
  input  logic            mode,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    data_out,
  output logic [SELW-1:0] sel_out
);

`ifdef MUX_PIPE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif
  // Depth of the select side-pipe: one entry per registered stage.
  localparam int D = PIPE ? SELW : 1;

  logic            en;
  logic            accept;
  logic [SELW-1:0] scan_cnt;
  logic [SELW-1:0] eff_sel;
  logic [SELW-1:0] sel_pipe [D];
  logic [SELW-1:0] lvl_bit;

  // Heap-ordered tree: node j has children 2j and 2j+1, leaves N..2N-1 are the channels.
  logic [W-1:0]    t_data [1:2*N-1];
  logic            t_vld  [1:2*N-1];

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && en;
  assign eff_sel  = (mode == MODE_DIRECT) ? sel : scan_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
    end else if (accept && mode == MODE_SCAN) begin
      scan_cnt <= scan_cnt + SELW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < D; i++) sel_pipe[i] <= '0;
    end else if (en) begin
      sel_pipe[0] <= eff_sel;
      for (int i = 1; i < D; i++) sel_pipe[i] <= sel_pipe[i-1];
    end
  end

  generate
    // Level i steers with bit i of the select that entered alongside its data.
    for (genvar i = 0; i < SELW; i++) begin : g_lsel
      if (PIPE && i > 0) begin : g_piped
        assign lvl_bit[i] = sel_pipe[i-1][i];
      end else begin : g_direct
        assign lvl_bit[i] = eff_sel[i];
      end
    end

    for (genvar k = 0; k < N; k++) begin : g_leaf
      assign t_data[N+k] = data_in[k*W +: W];
      assign t_vld[N+k]  = in_valid;
    end

    for (genvar j = 1; j < N; j++) begin : g_node
      localparam int LVL = SELW - $clog2(j + 1);
      mux2_stage #(
        .W   (W),
        .REG (PIPE)
      ) u_mux2 (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sel       (lvl_bit[LVL]),
        .valid_in  (t_vld[2*j] & t_vld[2*j+1]),
        .d0        (t_data[2*j]),
        .d1        (t_data[2*j+1]),
        .q         (t_data[j]),
        .valid_out (t_vld[j])
      );
    end

    if (PIPE) begin : g_out_tree
      assign data_out  = t_data[1];
      assign out_valid = t_vld[1];
    end else begin : g_out_reg
      always_ff @(posedge clk) begin
        if (rst) begin
          data_out  <= '0;
          out_valid <= 1'b0;
        end else if (en) begin
          data_out  <= t_data[1];
          out_valid <= t_vld[1];
        end
      end
    end
  endgenerate

  assign sel_out = sel_pipe[D-1];

endmodule

// File: tb/tb_pipelined_nbyone_mux.sv
// Self-checking bench for pipelined_nbyone_mux: a 4x8 instance for directed scenarios, a 16x32 one for a random sweep.
module tb_pipelined_nbyone_mux;

`ifdef MUX_PIPE_EN
  localparam int L4  = 2;
  localparam int L16 = 4;
`else
  localparam int L4  = 1;
  localparam int L16 = 1;
`endif

  int errors = 0;
  int checks = 0;
  int cyc_n  = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0]  d4;
  logic [1:0]   sel4, so4;
  logic         mode4, iv4, ir4, ov4, or4;
  logic [7:0]   do4;

  logic [511:0] d16;
  logic [3:0]   sel16, so16;
  logic         mode16, iv16, ir16, ov16, or16;
  logic [31:0]  do16;

  pipelined_nbyone_mux #(.N(4), .W(8)) dut4 (
    .clk (clk), .rst (rst), .data_in (d4), .sel (sel4), .mode (mode4),
    .in_valid (iv4), .in_ready (ir4), .out_valid (ov4), .out_ready (or4),
    .data_out (do4), .sel_out (so4)
  );

  pipelined_nbyone_mux #(.N(16), .W(32)) dut16 (
    .clk (clk), .rst (rst), .data_in (d16), .sel (sel16), .mode (mode16),
    .in_valid (iv16), .in_ready (ir16), .out_valid (ov16), .out_ready (or16),
    .data_out (do16), .sel_out (so16)
  );

  // Reference model: ordered queue of accepted (channel data, channel index) plus a scan count.
  logic [7:0]  q4_d[$];
  logic [1:0]  q4_s[$];
  int          q4_t[$];
  int          cnt4 = 0;
  logic [31:0] q16_d[$];
  logic [3:0]  q16_s[$];
  int          cnt16 = 0;

  bit          c_acc, c_took, c_hit, c_ov, c_ir;
  logic [7:0]  c_obs_d, c_exp_d;
  logic [1:0]  c_obs_s, c_exp_s;
  int          c_lat;
  bit          k_acc, k_took, k_hit;
  logic [31:0] k_obs_d, k_exp_d;
  logic [3:0]  k_obs_s, k_exp_s;

  task automatic cycle4(input logic v, input logic [31:0] d, input logic [1:0] s,
                        input logic m, input logic r);
    int eff;
    iv4 = v; d4 = d; sel4 = s; mode4 = m; or4 = r;
    #1;
    c_ir = ir4; c_ov = ov4; c_acc = v && ir4; c_took = ov4 && r;
    c_obs_d = do4; c_obs_s = so4;
    c_hit = 1'b0; c_exp_d = '0; c_exp_s = '0; c_lat = 0;
    if (c_took && q4_d.size() > 0) begin
      c_hit = 1'b1;
      c_exp_d = q4_d.pop_front();
      c_exp_s = q4_s.pop_front();
      c_lat = cyc_n - q4_t.pop_front();
    end
    if (c_acc) begin
      eff = m ? cnt4 : int'(s);
      q4_d.push_back(8'(d >> (eff * 8)));
      q4_s.push_back(2'(eff));
      q4_t.push_back(cyc_n);
      if (m) cnt4 = (cnt4 + 1) % 4;
    end
    @(posedge clk); #1; cyc_n++;
  endtask

  task automatic cycle16(input logic v, input logic [511:0] d, input logic [3:0] s,
                         input logic m, input logic r);
    int eff;
    iv16 = v; d16 = d; sel16 = s; mode16 = m; or16 = r;
    #1;
    k_acc = v && ir16; k_took = ov16 && r;
    k_obs_d = do16; k_obs_s = so16;
    k_hit = 1'b0; k_exp_d = '0; k_exp_s = '0;
    if (k_took && q16_d.size() > 0) begin
      k_hit = 1'b1;
      k_exp_d = q16_d.pop_front();
      k_exp_s = q16_s.pop_front();
    end
    if (k_acc) begin
      eff = m ? cnt16 : int'(s);
      q16_d.push_back(32'(d >> (eff * 32)));
      q16_s.push_back(4'(eff));
      if (m) cnt16 = (cnt16 + 1) % 16;
    end
    @(posedge clk); #1; cyc_n++;
  endtask

  // Inputs are left active during reset to show they are ignored.
  task automatic do_reset();
    rst = 1'b1; iv4 = 1'b1; iv16 = 1'b1; or4 = 1'b1; or16 = 1'b1; mode4 = 1'b1; mode16 = 1'b1;
    @(posedge clk); #1; cyc_n++;
    rst = 1'b0; iv4 = 1'b0; iv16 = 1'b0;
    q4_d.delete(); q4_s.delete(); q4_t.delete(); cnt4 = 0;
    q16_d.delete(); q16_s.delete(); cnt16 = 0;
  endtask

  task automatic drain4(input string tag);
    for (int i = 0; i < 20 && q4_d.size() > 0; i++) begin
      cycle4(1'b0, '0, '0, 1'b0, 1'b1);
      if (c_took) begin
        checks++;
        if (!c_hit || c_obs_d !== c_exp_d || c_obs_s !== c_exp_s) begin
          errors++;
          $display("FAIL %s_drain: got data=%h sel=%0d, want data=%h sel=%0d", tag, c_obs_d, c_obs_s, c_exp_d, c_exp_s);
        end
      end
    end
    checks++;
    if (q4_d.size() != 0) begin
      errors++;
      $display("FAIL %s_drain_timeout: %0d results still owed, want 0", tag, q4_d.size());
    end
  endtask

  task automatic test_reset();
    or4 = 1'b0; or16 = 1'b0;
    #1;
    checks += 8;
    if (ov4 !== 1'b0)   begin errors++; $display("FAIL rst_ov4: got %b want 0", ov4); end
    if (do4 !== 8'h00)  begin errors++; $display("FAIL rst_do4: got %h want 00", do4); end
    if (so4 !== 2'd0)   begin errors++; $display("FAIL rst_so4: got %0d want 0", so4); end
    if (ir4 !== 1'b1)   begin errors++; $display("FAIL rst_ir4: got %b want 1", ir4); end
    if (ov16 !== 1'b0)  begin errors++; $display("FAIL rst_ov16: got %b want 0", ov16); end
    if (do16 !== 32'h0) begin errors++; $display("FAIL rst_do16: got %h want 0", do16); end
    if (so16 !== 4'd0)  begin errors++; $display("FAIL rst_so16: got %0d want 0", so16); end
    if (ir16 !== 1'b1)  begin errors++; $display("FAIL rst_ir16: got %b want 1", ir16); end
    @(posedge clk); #1; cyc_n++;
  endtask

  task automatic test_direct();
    int seen = 0;
    cycle4(1'b1, 32'hDDCC_BBAA, 2'd2, 1'b0, 1'b1);
    for (int i = 0; i < L4 + 3; i++) begin
      cycle4(1'b0, $urandom, 2'($urandom), 1'b0, 1'b1);
      if (c_took) begin
        seen++;
        checks++;
        if (c_obs_d !== 8'hCC || c_obs_s !== 2'd2 || c_lat != L4) begin
          errors++;
          $display("FAIL direct: got data=%h sel=%0d lat=%0d, want data=cc sel=2 lat=%0d", c_obs_d, c_obs_s, c_lat, L4);
        end
      end
    end
    checks++;
    if (seen != 1) begin errors++; $display("FAIL direct_count: got %0d valid cycles want 1", seen); end
  endtask

  task automatic test_scan_wrap();
    logic [1:0] exp_seq [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    int n = 0;
    int last = -1;
    for (int i = 0; i < 6 + L4 + 2; i++) begin
      cycle4(i < 6, $urandom, 2'($urandom), 1'b1, 1'b1);
      if (c_took) begin
        checks++;
        if (!c_hit || c_obs_d !== c_exp_d || c_obs_s !== c_exp_s) begin
          errors++;
          $display("FAIL scan_data: got data=%h sel=%0d, want data=%h sel=%0d", c_obs_d, c_obs_s, c_exp_d, c_exp_s);
        end
        if (n < 6) begin
          checks++;
          if (c_obs_s !== exp_seq[n]) begin errors++; $display("FAIL scan_seq[%0d]: got %0d want %0d", n, c_obs_s, exp_seq[n]); end
        end
        if (last >= 0) begin
          checks++;
          if (i != last + 1) begin errors++; $display("FAIL scan_gap: result at cycle %0d, want %0d", i, last + 1); end
        end
        last = i;
        n++;
      end
    end
    checks++;
    if (n != 6) begin errors++; $display("FAIL scan_count: got %0d results want 6", n); end
  endtask

  task automatic test_backpressure();
    logic [7:0] held_d;
    logic [1:0] held_s;
    int stall = 0;
    for (int i = 0; i < 20 && stall < 5; i++) begin
      cycle4(1'b1, $urandom, 2'($urandom), 1'b1, 1'b0);
      if (c_ov) begin
        if (stall == 0) begin
          held_d = c_obs_d; held_s = c_obs_s;
        end else begin
          checks++;
          if (c_obs_d !== held_d || c_obs_s !== held_s) begin
            errors++;
            $display("FAIL bp_stable: got data=%h sel=%0d, want data=%h sel=%0d", c_obs_d, c_obs_s, held_d, held_s);
          end
        end
        checks++;
        if (c_ir !== 1'b0 || c_acc) begin errors++; $display("FAIL bp_ready: got in_ready=%b want 0", c_ir); end
        stall++;
      end
    end
    checks++;
    if (stall != 5) begin errors++; $display("FAIL bp_timeout: got %0d stalled cycles want 5", stall); end
    checks++;
    if (q4_d.size() == 0 || held_d !== q4_d[0] || held_s !== q4_s[0]) begin
      errors++;
      $display("FAIL bp_held: got data=%h sel=%0d, want oldest accepted", held_d, held_s);
    end
    for (int j = 0; j < L4 + 2; j++) begin
      cycle4(1'b1, $urandom, 2'($urandom), 1'b1, 1'b1);
      checks++;
      if (!c_took || !c_hit || c_obs_d !== c_exp_d || c_obs_s !== c_exp_s) begin
        errors++;
        $display("FAIL bp_release[%0d]: got valid=%b data=%h sel=%0d, want data=%h sel=%0d", j, c_took, c_obs_d, c_obs_s, c_exp_d, c_exp_s);
      end
    end
    drain4("bp");
  endtask

  task automatic test_mode_switch();
    logic [1:0] exp_seq [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd3};
    int n = 0;
    do_reset();
    for (int i = 0; i < 6 + L4 + 2; i++) begin
      cycle4(i < 6, $urandom, 2'd0, (i < 3 || i == 5), 1'b1);
      if (c_took) begin
        checks++;
        if (!c_hit || c_obs_d !== c_exp_d || c_obs_s !== c_exp_s) begin
          errors++;
          $display("FAIL mode_data: got data=%h sel=%0d, want data=%h sel=%0d", c_obs_d, c_obs_s, c_exp_d, c_exp_s);
        end
        if (n < 6) begin
          checks++;
          if (c_obs_s !== exp_seq[n]) begin errors++; $display("FAIL mode_seq[%0d]: got %0d want %0d", n, c_obs_s, exp_seq[n]); end
        end
        n++;
      end
    end
    checks++;
    if (n != 6) begin errors++; $display("FAIL mode_count: got %0d results want 6", n); end
  endtask

  task automatic test_reset_midstream();
    int n = 0;
    for (int i = 0; i < L4; i++) cycle4(1'b1, $urandom, 2'($urandom), 1'b1, 1'b1);
    do_reset();
    or4 = 1'b0;
    #1;
    checks += 4;
    if (ov4 !== 1'b0)  begin errors++; $display("FAIL mid_ov: got %b want 0", ov4); end
    if (do4 !== 8'h00) begin errors++; $display("FAIL mid_do: got %h want 00", do4); end
    if (so4 !== 2'd0)  begin errors++; $display("FAIL mid_so: got %0d want 0", so4); end
    if (ir4 !== 1'b1)  begin errors++; $display("FAIL mid_ir: got %b want 1", ir4); end
    for (int i = 0; i < L4 + 3; i++) begin
      cycle4(1'b0, $urandom, 2'($urandom), 1'b1, 1'b1);
      checks++;
      if (c_ov !== 1'b0) begin errors++; $display("FAIL mid_stale[%0d]: got out_valid=%b want 0", i, c_ov); end
    end
    cycle4(1'b1, 32'h4433_2211, 2'd3, 1'b1, 1'b1);
    for (int i = 0; i < L4 + 2; i++) begin
      cycle4(1'b0, '0, '0, 1'b0, 1'b1);
      if (c_took) begin
        n++;
        checks++;
        if (c_obs_s !== 2'd0 || c_obs_d !== 8'h11) begin
          errors++;
          $display("FAIL mid_scan0: got data=%h sel=%0d, want data=11 sel=0", c_obs_d, c_obs_s);
        end
      end
    end
    checks++;
    if (n != 1) begin errors++; $display("FAIL mid_count: got %0d results want 1", n); end
  endtask

  task automatic test_sweep16();
    logic [511:0] d;
    int takes = 0;
    int accs  = 0;
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
      cycle16($urandom_range(99) < 75, d, 4'($urandom), 1'($urandom), $urandom_range(99) < 70);
      if (k_acc) accs++;
      if (k_took) begin
        takes++;
        checks++;
        if (!k_hit || k_obs_d !== k_exp_d || k_obs_s !== k_exp_s) begin
          errors++;
          $display("FAIL sweep[%0d]: got data=%h sel=%0d, want data=%h sel=%0d", i, k_obs_d, k_obs_s, k_exp_d, k_exp_s);
        end
      end
    end
    for (int i = 0; i < L16 + 40 && q16_d.size() > 0; i++) begin
      cycle16(1'b0, '0, '0, 1'b0, 1'b1);
      if (k_took) begin
        takes++;
        checks++;
        if (!k_hit || k_obs_d !== k_exp_d || k_obs_s !== k_exp_s) begin
          errors++;
          $display("FAIL sweep_drain: got data=%h sel=%0d, want data=%h sel=%0d", k_obs_d, k_obs_s, k_exp_d, k_exp_s);
        end
      end
    end
    checks++;
    if (q16_d.size() != 0 || takes != accs) begin
      errors++;
      $display("FAIL sweep_count: got %0d results want %0d", takes, accs);
    end
  endtask

  initial begin
    iv4 = 1'b0; d4 = '0; sel4 = '0; mode4 = 1'b0; or4 = 1'b0;
    iv16 = 1'b0; d16 = '0; sel16 = '0; mode16 = 1'b0; or16 = 1'b0;
    do_reset();
    test_reset();
    test_direct();
    test_scan_wrap();
    test_backpressure();
    test_mode_switch();
    test_reset_midstream();
    test_sweep16();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
